// File: rtl/mic1_mem_responder.sv
// Memory-side responder for the MIC-1 datapath: word rd/wr through MAR/MDR,
// big-endian byte fetch through PC, fixed-latency responses and a preload port.
module mic1_mem_responder #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd,
  input  logic              wr,
  input  logic              fetch,
  input  logic [31:0]       mar,
  input  logic [31:0]       mdr_in,
  input  logic [31:0]       pc,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  output logic [31:0]       mdr_out,
  output logic              mdr_valid,
  output logic [7:0]        mbr_out,
  output logic              mbr_valid,
  output logic              err
);

  localparam int unsigned DEPTH  = 32'd1 << ADDR_W;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned LAST   = LATENCY - 1;

  typedef struct packed {
    logic              vld;
    logic              err;
    logic [WORD_W-1:0] dat;
  } word_stage_t;

  typedef struct packed {
    logic              vld;
    logic              err;
    logic [BYTE_W-1:0] dat;
  } byte_stage_t;

  logic [WORD_W-1:0] mem [DEPTH];

  word_stage_t w_pipe [LATENCY];
  byte_stage_t b_pipe [LATENCY];

  logic              accept_c;
  logic              mar_oor_c;
  logic              pc_oor_c;
  logic              wr_commit_c;
  logic [WORD_W-1:0] rd_word_c;
  logic [WORD_W-1:0] fetch_word_c;
  logic [BYTE_W-1:0] fetch_byte_c;
  word_stage_t       w_next_c;
  byte_stage_t       b_next_c;

  // A preload cycle owns the memory; datapath strobes in that cycle are ignored.
  assign accept_c    = ~ld_en;
  assign mar_oor_c   = |mar[31:ADDR_W];
  assign pc_oor_c    = |pc[31:ADDR_W+2];
  assign wr_commit_c = accept_c & rst & wr & ~mar_oor_c;

  // Reads see memory as of the sampling edge, so same-edge writes return old data.
  assign rd_word_c    = mar_oor_c ? '0 : mem[mar[ADDR_W-1:0]];
  assign fetch_word_c = pc_oor_c  ? '0 : mem[pc[ADDR_W+1:2]];

  always_comb begin
    fetch_byte_c = '0;
    case (pc[1:0])
      2'd0:    fetch_byte_c = fetch_word_c[31:24];
      2'd1:    fetch_byte_c = fetch_word_c[23:16];
      2'd2:    fetch_byte_c = fetch_word_c[15:8];
      default: fetch_byte_c = fetch_word_c[7:0];
    endcase
  end

  // Stage-0 payloads; a single err bit covers rd and wr both out of range.
  always_comb begin
    w_next_c     = '0;
    w_next_c.vld = accept_c & rd;
    w_next_c.err = accept_c & (rd | wr) & mar_oor_c;
    w_next_c.dat = rd_word_c;
    b_next_c     = '0;
    b_next_c.vld = accept_c & fetch;
    b_next_c.err = accept_c & fetch & pc_oor_c;
    b_next_c.dat = fetch_byte_c;
  end

  // Main memory: preload port has priority, no reset on the array.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end else if (wr_commit_c) begin
      mem[mar[ADDR_W-1:0]] <= mdr_in;
    end
  end

  // Word channel shift register and MDR-side outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        w_pipe[i] <= '0;
      end
      mdr_out   <= '0;
      mdr_valid <= 1'b0;
    end else begin
      w_pipe[0] <= w_next_c;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        w_pipe[i] <= w_pipe[i-1];
      end
      mdr_valid <= w_pipe[LAST].vld;
      if (w_pipe[LAST].vld) begin
        mdr_out <= w_pipe[LAST].dat;
      end
    end
  end

  // Byte channel shift register and MBR-side outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        b_pipe[i] <= '0;
      end
      mbr_out   <= '0;
      mbr_valid <= 1'b0;
    end else begin
      b_pipe[0] <= b_next_c;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        b_pipe[i] <= b_pipe[i-1];
      end
      mbr_valid <= b_pipe[LAST].vld;
      if (b_pipe[LAST].vld) begin
        mbr_out <= b_pipe[LAST].dat;
      end
    end
  end

  // Range error is merged across channels at the output stage.
  always_ff @(posedge clk) begin
    if (!rst) begin
      err <= 1'b0;
    end else begin
      err <= w_pipe[LAST].err | b_pipe[LAST].err;
    end
  end

endmodule

// File: tb/tb_mic1_mem_responder.sv
// Bench for mic1_mem_responder: LATENCY=1 and LATENCY=3 instances share stimulus
// and are compared every cycle against a cycle-indexed response schedule model.
module tb_mic1_mem_responder;

  logic        clk = 1'b0;
  logic        rst, rd, wr, fetch, ld_en;
  logic [31:0] mar, mdr_in, pc, ld_data;
  logic [9:0]  ld_addr;

  logic [31:0] mdr_o [2];
  logic        mdr_v [2];
  logic [7:0]  mbr_o [2];
  logic        mbr_v [2];
  logic        err_o [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mic1_mem_responder #(.ADDR_W(10), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .rd(rd), .wr(wr), .fetch(fetch),
    .mar(mar), .mdr_in(mdr_in), .pc(pc),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .mdr_out(mdr_o[0]), .mdr_valid(mdr_v[0]), .mbr_out(mbr_o[0]),
    .mbr_valid(mbr_v[0]), .err(err_o[0])
  );

  mic1_mem_responder #(.ADDR_W(10), .LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .rd(rd), .wr(wr), .fetch(fetch),
    .mar(mar), .mdr_in(mdr_in), .pc(pc),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .mdr_out(mdr_o[1]), .mdr_valid(mdr_v[1]), .mbr_out(mbr_o[1]),
    .mbr_valid(mbr_v[1]), .err(err_o[1])
  );

  // Reference model: memory image plus responses scheduled by due edge.
  logic [31:0] mem_m [1024];
  bit          s_mv [2][8];
  bit          s_bv [2][8];
  bit          s_er [2][8];
  logic [31:0] s_md [2][8];
  logic [7:0]  s_mb [2][8];
  logic [31:0] e_md [2];
  logic [7:0]  e_mb [2];
  bit          e_mv [2];
  bit          e_bv [2];
  bit          e_er [2];
  int          cyc = 0;
  int          lat [2] = '{1, 3};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_step();
    bit          rd_oor, wr_oor, f_oor;
    logic [31:0] word, fword;
    logic [7:0]  fbyte;
    int          slot, sh;
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < 8; i++) begin
          s_mv[d][i] = 0; s_bv[d][i] = 0; s_er[d][i] = 0;
        end
        e_md[d] = '0; e_mb[d] = '0; e_mv[d] = 0; e_bv[d] = 0; e_er[d] = 0;
      end
      if (ld_en) mem_m[ld_addr] = ld_data;
    end else begin
      for (int d = 0; d < 2; d++) begin
        slot = cyc % 8;
        e_mv[d] = s_mv[d][slot];
        e_bv[d] = s_bv[d][slot];
        e_er[d] = s_er[d][slot];
        if (s_mv[d][slot]) e_md[d] = s_md[d][slot];
        if (s_bv[d][slot]) e_mb[d] = s_mb[d][slot];
        s_mv[d][slot] = 0; s_bv[d][slot] = 0; s_er[d][slot] = 0;
      end
      if (ld_en) begin
        mem_m[ld_addr] = ld_data;
      end else begin
        rd_oor = (mar > 32'd1023);
        wr_oor = rd_oor;
        f_oor  = (pc > 32'd4095);
        word   = rd_oor ? 32'd0 : mem_m[mar % 1024];
        fword  = f_oor ? 32'd0 : mem_m[(pc / 4) % 1024];
        sh     = 8 * (3 - int'(pc % 4));
        fbyte  = 8'((fword >> sh) & 32'hFF);
        for (int d = 0; d < 2; d++) begin
          slot = (cyc + lat[d]) % 8;
          s_mv[d][slot] = rd;
          s_md[d][slot] = word;
          s_bv[d][slot] = fetch;
          s_mb[d][slot] = fbyte;
          s_er[d][slot] = (rd && rd_oor) || (wr && wr_oor) || (fetch && f_oor);
        end
        if (wr && !wr_oor) mem_m[mar % 1024] = mdr_in;
      end
    end
  endtask

  // One clock: model follows the edge, outputs checked 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("mdr_out[L%0d]", lat[d]), mdr_o[d], e_md[d]);
      chk($sformatf("mdr_valid[L%0d]", lat[d]), 32'(mdr_v[d]), 32'(e_mv[d]));
      chk($sformatf("mbr_out[L%0d]", lat[d]), 32'(mbr_o[d]), 32'(e_mb[d]));
      chk($sformatf("mbr_valid[L%0d]", lat[d]), 32'(mbr_v[d]), 32'(e_bv[d]));
      chk($sformatf("err[L%0d]", lat[d]), 32'(err_o[d]), 32'(e_er[d]));
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle();
    rd = 0; wr = 0; fetch = 0; ld_en = 0;
  endtask

  task automatic load(input logic [9:0] a, input logic [31:0] v);
    idle(); ld_en = 1; ld_addr = a; ld_data = v;
    tick();
    ld_en = 0;
  endtask

  function automatic logic [31:0] rand_addr(input int unsigned lim);
    int unsigned r;
    r = $urandom_range(0, 15);
    if (r == 0) return $urandom | (lim + 1);
    if (r < 10) return 32'($urandom_range(0, 15));
    return 32'($urandom_range(0, lim));
  endfunction

  logic [7:0]  lanes [4];
  logic [31:0] m0;

  initial begin
    lanes[0] = 8'h11; lanes[1] = 8'h22; lanes[2] = 8'h33; lanes[3] = 8'h44;
    idle();
    mar = 0; mdr_in = 0; pc = 0; ld_addr = 0; ld_data = 0;
    // Reset held with rd asserted, then released.
    rst = 0; rd = 1; mar = 32'd5;
    tick(); tick();
    chk("reset_mdr_out", mdr_o[0], 32'd0);
    rst = 1; rd = 0;
    for (int i = 0; i < 4; i++) tick();

    for (int i = 0; i < 1024; i++) load(10'(i), $urandom);

    // Preload then read.
    load(10'd5, 32'hDEADBEEF);
    rd = 1; mar = 32'd5; tick();
    rd = 0; tick();
    chk("preload_rd_data", mdr_o[0], 32'hDEADBEEF);
    chk("preload_rd_valid", 32'(mdr_v[0]), 32'd1);
    tick();
    chk("preload_rd_pulse_end", 32'(mdr_v[0]), 32'd0);

    // Byte lanes, back to back.
    load(10'd1, 32'h11223344);
    for (int i = 0; i < 4; i++) begin
      fetch = 1; pc = 32'(4 + i); tick();
      if (i > 0) chk("fetch_lane", 32'(mbr_o[0]), 32'(lanes[i-1]));
    end
    fetch = 0; tick();
    chk("fetch_lane_last", 32'(mbr_o[0]), 32'h44);

    // Read-before-write collision.
    load(10'd2, 32'hA);
    rd = 1; wr = 1; mar = 32'd2; mdr_in = 32'hB; tick();
    wr = 0; tick();
    chk("collision_old", mdr_o[0], 32'hA);
    rd = 0; tick();
    chk("collision_new", mdr_o[0], 32'hB);

    // Out of range read and write.
    m0 = mem_m[0];
    rd = 1; mar = 32'h400; tick();
    rd = 0; tick();
    chk("oor_rd_data", mdr_o[0], 32'd0);
    chk("oor_rd_err", 32'(err_o[0]), 32'd1);
    chk("oor_rd_valid", 32'(mdr_v[0]), 32'd1);
    wr = 1; mar = 32'h400; mdr_in = 32'hFFFF_FFFF; tick();
    wr = 0; rd = 1; mar = 32'd0; tick();
    chk("oor_wr_err", 32'(err_o[0]), 32'd1);
    rd = 0; tick();
    chk("oor_wr_mem0", mdr_o[0], m0);

    // Reset while a LATENCY=3 read is in flight.
    for (int i = 0; i < 2; i++) tick();
    rd = 1; mar = 32'd5; tick();
    rd = 0; rst = 0; tick();
    rst = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("midflight_valid", 32'(mdr_v[1]), 32'd0);
      chk("midflight_data", mdr_o[1], 32'd0);
    end

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      rst     = ($urandom_range(0, 63) != 0);
      ld_en   = ($urandom_range(0, 19) == 0);
      ld_addr = 10'($urandom);
      ld_data = $urandom;
      rd      = 1'($urandom);
      wr      = ($urandom_range(0, 2) == 0);
      fetch   = 1'($urandom);
      mar     = rand_addr(32'd1023);
      pc      = rand_addr(32'd4095);
      mdr_in  = $urandom;
      tick();
    end
    idle(); rst = 1;
    for (int i = 0; i < 5; i++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
